multicycle_control: RTL and testbench



---
 rtl/multicycle_control_if.sv | 36 +++
 rtl/multicycle_control.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and the datapath.
// The controller drives the master modport; the datapath (or the instruction
// register for Opcode) sits on the slave modport.
interface multicycle_control_if #(
    parameter int OPCODE_WIDTH = 6
);
    logic [OPCODE_WIDTH-1:0] Opcode;
    logic                    PCWrite;
    logic                    PCWriteCond;
    logic                    IRWrite;
    logic                    RegWrite;
    logic                    MemWrite;
    logic                    MemAddr;
    logic                    ALUSrcA;
    logic                    RegRead;
    logic [1:0]              ALUSrcB;
    logic [1:0]              MemtoReg;
    logic [1:0]              PCSource;
    logic [1:0]              BranchCond;
    logic [2:0]              ALUSelect;
    logic                    Halted;

    modport master (
        input  Opcode,
        output PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite,
        output MemAddr, ALUSrcA, RegRead, ALUSrcB, MemtoReg,
        output PCSource, BranchCond, ALUSelect, Halted
    );

    modport slave (
        output Opcode,
        input  PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite,
        input  MemAddr, ALUSrcA, RegRead, ALUSrcB, MemtoReg,
        input  PCSource, BranchCond, ALUSelect, Halted
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore controller for the 32-bit multicycle CPU.
// Outputs are a pure decode of the state register (plus the opcode latched in
// DECODE); the only exception is RegRead during DECODE, which must follow the
// freshly loaded IR so read port 2 fetches the right register that cycle.
// Write enables are gated by Reset so they drop the instant reset asserts.
// Optional feature: define ILLEGAL_TRAP_EN to send illegal opcodes to HALT
// instead of treating them as a 2-cycle NOP.
module multicycle_control #(
    parameter int OPCODE_WIDTH = 6
) (
    input  logic                Clk,
    input  logic                Reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_LI_WB,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_LI   = 6'b011000;
    localparam logic [5:0] OP_LUI  = 6'b011001;
    localparam logic [5:0] OP_LW   = 6'b011010;
    localparam logic [5:0] OP_SW   = 6'b011011;
    localparam logic [5:0] OP_LWI  = 6'b011100;
    localparam logic [5:0] OP_SWI  = 6'b011101;
    localparam logic [5:0] OP_JMP  = 6'b101000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

`ifdef ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = S_HALT;
`else
    localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] op_in;

    // The instruction field of interest is always the top six opcode bits.
    assign op_in = bus.Opcode[OPCODE_WIDTH-1 -: 6];

    // Next-state logic; opcode is captured in DECODE and consulted again in MEM_ADDR.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d = op_in;
                if (op_in[5:3] == 3'b000) begin
                    state_d = S_EXEC_R;
                end else if (op_in[5:3] == 3'b001 || op_in[5:3] == 3'b010) begin
                    state_d = S_EXEC_I;
                end else begin
                    casez (op_in)
                        OP_LI, OP_LUI: state_d = S_LI_WB;
                        OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                        OP_LWI:        state_d = S_MEM_READ;
                        OP_SWI:        state_d = S_MEM_WRITE;
                        6'b1000??:     state_d = S_BRANCH;
                        OP_JMP:        state_d = S_JUMP;
                        OP_HALT:       state_d = S_HALT;
                        default:       state_d = ILLEGAL_NEXT;
                    endcase
                end
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_MEM_ADDR:  state_d = op_in[0] ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase
    end

    // State and latched opcode; reset lands directly in FETCH.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    logic       pc_write, pc_write_cond, ir_write, reg_write, mem_write;
    logic       mem_addr, alu_src_a, reg_read, halted;
    logic [1:0] alu_src_b, mem_to_reg, pc_source, branch_cond;
    logic [2:0] alu_select;

    // Moore output decode per state.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        mem_addr      = 1'b0;
        alu_src_a     = 1'b0;
        reg_read      = 1'b0;
        halted        = 1'b0;
        alu_src_b     = 2'b00;
        mem_to_reg    = 2'b00;
        pc_source     = 2'b00;
        branch_cond   = 2'b00;
        alu_select    = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
            end
            S_DECODE: begin
                // Branch target into ALUOut; stores and branches need rd on port 2.
                alu_src_b = 2'b10;
                reg_read  = (op_in == OP_SW) || (op_in == OP_SWI) ||
                            (op_in[5:2] == 4'b1000);
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_select = op_q[2:0];
            end
            S_EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = op_q[4] ? 2'b11 : 2'b10;
                alu_select = op_q[2:0];
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
            end
            S_LI_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = op_q[0] ? 2'b11 : 2'b01;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                reg_read  = op_q[0];
            end
            S_MEM_READ: begin
                mem_addr = (op_q == OP_LWI);
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                reg_read  = 1'b1;
                mem_addr  = (op_q == OP_SWI);
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_select    = ALU_SUB;
                reg_read      = 1'b1;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_cond   = op_q[1:0];
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are killed combinationally by reset so an aborted instruction
    // never completes a write in the cycle reset arrives.
    assign bus.PCWrite     = pc_write      & Reset;
    assign bus.PCWriteCond = pc_write_cond & Reset;
    assign bus.IRWrite     = ir_write      & Reset;
    assign bus.RegWrite    = reg_write     & Reset;
    assign bus.MemWrite    = mem_write     & Reset;
    assign bus.MemAddr     = mem_addr;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.RegRead     = reg_read;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.PCSource    = pc_source;
    assign bus.BranchCond  = branch_cond;
    assign bus.ALUSelect   = alu_select;
    assign bus.Halted      = halted;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the stimulus side expands each
// opcode into its expected per-cycle control words; the monitor pops one word
// per cycle and compares it with the DUT outputs.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       irw;
        logic       rgw;
        logic       mw;
        logic       maddr;
        logic       srca;
        logic       rr;
        logic [1:0] srcb;
        logic [1:0] m2r;
        logic [1:0] pcs;
        logic [1:0] bc;
        logic [2:0] alu;
        logic       halted;
    } ctl_t;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    int   cyc = 0;
    ctl_t exp_q[$];

    multicycle_control_if #(.OPCODE_WIDTH(6)) bus ();
    multicycle_control #(.OPCODE_WIDTH(6)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    function automatic ctl_t sample();
        ctl_t c;
        c.pcw = bus.PCWrite;     c.pcwc = bus.PCWriteCond; c.irw = bus.IRWrite;
        c.rgw = bus.RegWrite;    c.mw = bus.MemWrite;      c.maddr = bus.MemAddr;
        c.srca = bus.ALUSrcA;    c.rr = bus.RegRead;       c.srcb = bus.ALUSrcB;
        c.m2r = bus.MemtoReg;    c.pcs = bus.PCSource;     c.bc = bus.BranchCond;
        c.alu = bus.ALUSelect;   c.halted = bus.Halted;
        return c;
    endfunction

    function automatic ctl_t reset_vec();
        ctl_t c = '0;
        c.srcb = 2'b01;
        return c;
    endfunction

    function automatic ctl_t halt_vec();
        ctl_t c = '0;
        c.halted = 1'b1;
        return c;
    endfunction

    task automatic check(input string name, input ctl_t act, input ctl_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Reference model: expand one instruction into its expected cycles.
    // Returns the cycle count and whether the instruction ends in HALT.
    function automatic void model(input logic [5:0] op, output int len, output bit halts);
        ctl_t c;
        logic [2:0] cls = op[5:3];
        bit is_br = (op >= 6'd32) && (op <= 6'd35);
        halts = 1'b0;
        c = '0; c.irw = 1'b1; c.pcw = 1'b1; c.srcb = 2'b01;
        exp_q.push_back(c);
        c = '0; c.srcb = 2'b10;
        c.rr = (op == 6'b011011) || (op == 6'b011101) || is_br;
        exp_q.push_back(c);
        if (cls <= 3'd2) begin
            c = '0; c.srca = 1'b1; c.alu = op[2:0];
            c.srcb = (cls == 3'd0) ? 2'b00 : (cls == 3'd1) ? 2'b10 : 2'b11;
            exp_q.push_back(c);
            c = '0; c.rgw = 1'b1;
            exp_q.push_back(c);
            len = 4;
        end else if (op == 6'b011000 || op == 6'b011001) begin
            c = '0; c.rgw = 1'b1; c.m2r = (op == 6'b011001) ? 2'b11 : 2'b01;
            exp_q.push_back(c);
            len = 3;
        end else if (op == 6'b011010 || op == 6'b011011) begin
            c = '0; c.srca = 1'b1; c.srcb = 2'b10; c.rr = (op == 6'b011011);
            exp_q.push_back(c);
            if (op == 6'b011010) begin
                c = '0; exp_q.push_back(c);
                c = '0; c.rgw = 1'b1; c.m2r = 2'b10; exp_q.push_back(c);
                len = 5;
            end else begin
                c = '0; c.mw = 1'b1; c.rr = 1'b1; exp_q.push_back(c);
                len = 4;
            end
        end else if (op == 6'b011100) begin
            c = '0; c.maddr = 1'b1; exp_q.push_back(c);
            c = '0; c.rgw = 1'b1; c.m2r = 2'b10; exp_q.push_back(c);
            len = 4;
        end else if (op == 6'b011101) begin
            c = '0; c.mw = 1'b1; c.rr = 1'b1; c.maddr = 1'b1; exp_q.push_back(c);
            len = 3;
        end else if (is_br) begin
            c = '0; c.srca = 1'b1; c.alu = 3'b001; c.rr = 1'b1; c.pcwc = 1'b1;
            c.pcs = 2'b01; c.bc = op[1:0];
            exp_q.push_back(c);
            len = 3;
        end else if (op == 6'b101000) begin
            c = '0; c.pcw = 1'b1; c.pcs = 2'b10; exp_q.push_back(c);
            len = 3;
        end else if (op == 6'b111111) begin
            len = 2; halts = 1'b1;
        end else begin
            len = 2;
`ifdef ILLEGAL_TRAP_EN
            halts = 1'b1;
`endif
        end
    endfunction

    // Act as the instruction register: present the opcode after the FETCH edge.
    task automatic run_instr(input logic [5:0] op);
        int len;
        bit halts;
        model(op, len, halts);
        @(posedge Clk); #1 bus.Opcode = op;
        repeat (len - 1) @(posedge Clk);
        #1;
    endtask

    task automatic run_halt(input logic [5:0] op, input int n);
        int len;
        bit halts;
        model(op, len, halts);
        checks++;
        if (!halts) begin
            failures++;
            $display("FAIL halt_expected op=%b", op);
        end
        repeat (n) exp_q.push_back(halt_vec());
        @(posedge Clk); #1 bus.Opcode = op;
        repeat (n + 1) @(posedge Clk);
        #1 mon_en = 1'b0;
    endtask

    function automatic logic [5:0] rand_op(input bit allow_illegal);
        logic [5:0] ill [7] = '{6'b011110, 6'b011111, 6'b100100, 6'b101001,
                                6'b110000, 6'b110110, 6'b111110};
        logic [5:0] mem [6] = '{6'b011000, 6'b011001, 6'b011010, 6'b011011,
                                6'b011100, 6'b011101};
        int r = $urandom_range(0, 9);
        logic [5:0] op;
        if (r <= 2) begin
            op[5:3] = 3'($urandom_range(0, 2)); op[2:0] = 3'($urandom);
        end else if (r <= 5) begin
            op = mem[$urandom_range(0, 5)];
        end else if (r <= 7) begin
            op = 6'b100000 | 6'($urandom_range(0, 3));
        end else if (r == 8 || !allow_illegal) begin
            op = 6'b101000;
        end else begin
            op = ill[$urandom_range(0, 6)];
        end
        return op;
    endfunction

    // Monitor: one expected word per cycle, sampled mid-cycle.
    always @(negedge Clk) begin
        cyc <= cyc + 1;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow cycle=%0d", cyc);
            end else begin
                check($sformatf("ctl_cycle%0d", cyc), sample(), exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] dir [11] = '{6'b000001, 6'b011010, 6'b011100, 6'b100010,
                                 6'b011011, 6'b011101, 6'b011000, 6'b011001,
                                 6'b101000, 6'b001010, 6'b010011};
        bit allow_ill;
`ifdef ILLEGAL_TRAP_EN
        allow_ill = 1'b0;
`else
        allow_ill = 1'b1;
`endif
        bus.Opcode = 6'b111111;
        Reset = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            check("reset_state", sample(), reset_vec());
        end
        @(posedge Clk); #1 Reset = 1'b1; mon_en = 1'b1;

        foreach (dir[i]) run_instr(dir[i]);
        if (allow_ill) run_instr(6'b110110);
        repeat (60) run_instr(rand_op(allow_ill));

        // Reset in the MEM_WRITE cycle of SW must kill MemWrite immediately.
        mon_en = 1'b0;
        @(posedge Clk); #1 bus.Opcode = 6'b011011;
        repeat (2) @(posedge Clk);
        #1 check_bit("sw_memwrite_before_reset", bus.MemWrite, 1'b1);
        Reset = 1'b0;
        #1 check_bit("sw_memwrite_dropped", bus.MemWrite, 1'b0);
        check("sw_reset_state", sample(), reset_vec());
        @(posedge Clk); #1 Reset = 1'b1; mon_en = 1'b1;
        run_instr(6'b000001);
        run_instr(6'b100011);

`ifdef ILLEGAL_TRAP_EN
        run_halt(6'b110110, 20);
`else
        run_halt(6'b111111, 20);
`endif
        check_bit("halted_held", bus.Halted, 1'b1);

        Reset = 1'b0;
        #1 check("reset_from_halt", sample(), reset_vec());
        @(posedge Clk); #1 Reset = 1'b1; mon_en = 1'b1;
        run_instr(6'b001110);
        mon_en = 1'b0;

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
